uart_tx_periph: RTL

Memory-mapped UART transmitter slave on the 8-bit CPU bus, sitting directly downstream of the CPU's bus master port. The OUT opcode targets its TX data register at 0x80 and its status register at 0x82, and LOAD reads both. Written bytes are buffered in a small FIFO and serialised as 8N1 frames, LSB first, on the tx pin.

---
 rtl/uart_tx_periph_pkg.sv | 24 ++
 rtl/uart_tx_periph_if.sv | 16 +
 rtl/uart_tx_periph_sync_fifo.sv | 59 +++++
 rtl/uart_tx_periph.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets inside the 4-byte window, STATUS bit positions
// and the serialiser state encoding.
package uart_pkg;

  // Register offsets (bus_addr[1:0])
  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd2;

  // STATUS register bit positions
  localparam int BUSY  = 0;
  localparam int FULL  = 1;
  localparam int EMPTY = 2;
  localparam int OVF   = 3;

  // Serialiser states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_tx_periph_if.sv
// 8-bit CPU bus seen by the UART transmitter.
// master: CPU side, drives addr/wdata/we/valid, receives rdata/ready.
// slave : peripheral side.
interface uart_tx_periph_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       valid;
  logic [7:0] rdata;
  logic       ready;

  modport master (output addr, output wdata, output we, output valid,
                  input  rdata, input  ready);
  modport slave  (input  addr, input  wdata, input  we, input  valid,
                  output rdata, output ready);
endinterface

// File: rtl/uart_tx_periph_sync_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head, shown
// combinationally), full, empty. A push while full is taken only when a pop
// happens on the same edge; a pop while empty is ignored.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign rdata   = mem_r[rd_ptr_r];
  assign rd_en_s = pop && !empty;
  // Full plus a simultaneous pop frees the head slot on this same edge.
  assign wr_en_s = push && (!full || rd_en_s);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter slave.
// Ports: clk, rst_n (async active-low), bus (slave modport: addr, wdata, we,
// valid in; registered rdata, ready out), tx (serial line, idles high),
// tx_busy (registered, high while a frame is on the line).
// Window at BASE_ADDR: +0 TXDATA (write pushes FIFO), +2 STATUS
// {4'b0, overflow, empty, full, busy}; writing 1 to bit3 clears overflow.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h80,
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_periph_if.slave  bus,
  output logic             tx,
  output logic             tx_busy
);

  localparam int            TW       = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLK_DIV - 1);

  logic       hit_s, push_s, pop_s, ovf_clr_s, ovf_set_s;
  logic [1:0] ofs_s;
  logic [7:0] head_s, status_s, rd_val_s;
  logic       full_s, empty_s;

  logic [7:0] rdata_r;
  logic       ready_r, ovf_r;

  state_e        state_r, state_nx;
  logic [TW-1:0] timer_r, timer_nx;
  logic [7:0]    shift_r, shift_nx;
  logic [2:0]    idx_r, idx_nx;
  logic          tx_r, tx_nx, busy_r;
  logic          tick_s;

  assign hit_s     = bus.valid && (bus.addr[7:2] == BASE_ADDR[7:2]);
  assign ofs_s     = bus.addr[1:0];
  assign push_s    = hit_s && bus.we && (ofs_s == OFS_TXDATA);
  assign ovf_clr_s = hit_s && bus.we && (ofs_s == OFS_STATUS) && bus.wdata[OVF];
  // A pop on the same edge makes room, so a full FIFO only drops without one.
  assign ovf_set_s = push_s && full_s && !pop_s;
  assign status_s  = {4'b0000, ovf_r, empty_s, full_s, busy_r};

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (bus.wdata),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Read mux; only STATUS returns non-zero data.
  always_comb begin
    rd_val_s = 8'h00;
    case (ofs_s)
      OFS_STATUS: rd_val_s = status_s;
      default:    rd_val_s = 8'h00;
    endcase
  end

  // Bus response registers and the sticky overflow flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 8'h00;
      ready_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      ready_r <= hit_s;
      if (hit_s) rdata_r <= bus.we ? 8'h00 : rd_val_s;
      if (ovf_set_s)      ovf_r <= 1'b1;
      else if (ovf_clr_s) ovf_r <= 1'b0;
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;

  assign tick_s = (timer_r == '0);

  // Serialiser next state: each tx level is loaded with BIT_LOAD and held
  // until the timer reaches zero, giving CLK_DIV cycles per level.
  always_comb begin
    state_nx = state_r;
    timer_nx = tick_s ? timer_r : timer_r - TW'(1);
    shift_nx = shift_r;
    idx_nx   = idx_r;
    tx_nx    = tx_r;
    pop_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          shift_nx = head_s;
          tx_nx    = 1'b0;
          timer_nx = BIT_LOAD;
          state_nx = START;
        end else begin
          tx_nx = 1'b1;
        end
      end
      START: begin
        if (tick_s) begin
          idx_nx   = 3'd0;
          tx_nx    = shift_r[0];
          timer_nx = BIT_LOAD;
          state_nx = DATA;
        end else begin
          tx_nx = 1'b0;
        end
      end
      DATA: begin
        if (tick_s) begin
          timer_nx = BIT_LOAD;
          if (idx_r == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            shift_nx = {1'b0, shift_r[7:1]};
            idx_nx   = idx_r + 3'd1;
            tx_nx    = shift_r[1];
          end
        end else begin
          tx_nx = shift_r[0];
        end
      end
      STOP: begin
        if (tick_s && !empty_s) begin
          // Chain the next frame with no idle gap.
          pop_s    = 1'b1;
          shift_nx = head_s;
          tx_nx    = 1'b0;
          timer_nx = BIT_LOAD;
          state_nx = START;
        end else if (tick_s) begin
          tx_nx    = 1'b1;
          state_nx = IDLE;
        end else begin
          tx_nx = 1'b1;
        end
      end
      default: begin
        tx_nx    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Serialiser registers; reset aborts any frame and forces the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      timer_r <= '0;
      shift_r <= 8'h00;
      idx_r   <= 3'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      timer_r <= timer_nx;
      shift_r <= shift_nx;
      idx_r   <= idx_nx;
      tx_r    <= tx_nx;
      busy_r  <= (state_nx != IDLE);
    end
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;

endmodule
